// File: rtl/dmem_pkg.sv
// dmem_pkg
// Shared types and pure helpers for the data-memory access controller.
//   size_e        : access size encoding (2'b11 is illegal and has no member)
//   dmem_state_e  : controller FSM states
//   DMEM_DEPTH    : default memory depth in 32-bit words
//   load_extend   : pick byte/half out of a word and sign/zero extend it
//   store_merge   : replace byte/half lanes of a word with right-aligned data
package dmem_pkg;

  localparam int DMEM_DEPTH = 64;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RMW_RD = 2'b01,
    RMW_WR = 2'b10
  } dmem_state_e;

  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  offset,
                                              input logic [1:0]  size,
                                              input logic        is_unsigned);
    logic [7:0]  b;
    logic [15:0] h;
    case (offset)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = offset[1] ? word[31:16] : word[15:0];
    case (size)
      BYTE:    load_extend = is_unsigned ? {24'h0, b} : {{24{b[7]}}, b};
      HALF:    load_extend = is_unsigned ? {16'h0, h} : {{16{h[15]}}, h};
      default: load_extend = word;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [31:0] wdata,
                                              input logic [1:0]  offset,
                                              input logic [1:0]  size);
    store_merge = word;
    if (size == BYTE) begin
      case (offset)
        2'd0:    store_merge[7:0]   = wdata[7:0];
        2'd1:    store_merge[15:8]  = wdata[7:0];
        2'd2:    store_merge[23:16] = wdata[7:0];
        default: store_merge[31:24] = wdata[7:0];
      endcase
    end else if (size == HALF) begin
      if (offset[1]) store_merge[31:16] = wdata[15:0];
      else           store_merge[15:0]  = wdata[15:0];
    end
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// dmem_access_ctrl_if
// Bundles the two requester ports (p = pipeline MEM stage, d = debug/loader)
// and the word-only memory port of the data-memory access controller.
//   X_req_*  : request handshake and fields (valid/ready, we, size, unsigned, addr, wdata)
//   X_rsp_*  : one-cycle response pulse with extended read data and error flag
//   mem_*    : memory write enable, byte address, write data, combinational read data
// Modports: slave = the controller, master = requesters plus memory.
interface dmem_access_ctrl_if;
  logic        p_req_valid, p_req_ready, p_req_we, p_req_unsigned;
  logic [1:0]  p_req_size;
  logic [31:0] p_req_addr, p_req_wdata;
  logic        p_rsp_valid, p_rsp_err;
  logic [31:0] p_rsp_rdata;

  logic        d_req_valid, d_req_ready, d_req_we, d_req_unsigned;
  logic [1:0]  d_req_size;
  logic [31:0] d_req_addr, d_req_wdata;
  logic        d_rsp_valid, d_rsp_err;
  logic [31:0] d_rsp_rdata;

  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  modport slave (
    input  p_req_valid, p_req_we, p_req_unsigned, p_req_size, p_req_addr, p_req_wdata,
    output p_req_ready, p_rsp_valid, p_rsp_err, p_rsp_rdata,
    input  d_req_valid, d_req_we, d_req_unsigned, d_req_size, d_req_addr, d_req_wdata,
    output d_req_ready, d_rsp_valid, d_rsp_err, d_rsp_rdata,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output p_req_valid, p_req_we, p_req_unsigned, p_req_size, p_req_addr, p_req_wdata,
    input  p_req_ready, p_rsp_valid, p_rsp_err, p_rsp_rdata,
    output d_req_valid, d_req_we, d_req_unsigned, d_req_size, d_req_addr, d_req_wdata,
    input  d_req_ready, d_rsp_valid, d_rsp_err, d_rsp_rdata,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_rr_arb2.sv
// dmem_rr_arb2
// Two-requester round-robin arbiter. On a tie the requester not granted last
// wins; the pointer moves on every grant. Reset points at d so p wins the
// first tie.
//   i_clk, i_rst_n   : clock, asynchronous active-low reset
//   i_en             : grants are only issued while high
//   i_req_p, i_req_d : request lines
//   o_gnt_p, o_gnt_d : one-hot (or zero) combinational grants
module dmem_rr_arb2 (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_req_p,
  input  logic i_req_d,
  output logic o_gnt_p,
  output logic o_gnt_d
);
  logic r_last_d;

  assign o_gnt_p = i_en & i_req_p & (~i_req_d | r_last_d);
  assign o_gnt_d = i_en & i_req_d & (~i_req_p | ~r_last_d);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)     r_last_d <= 1'b1;
    else if (o_gnt_p) r_last_d <= 1'b0;
    else if (o_gnt_d) r_last_d <= 1'b1;
  end
endmodule

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl
// Data-memory front end shared by the pipeline (p) and debug/loader (d) ports.
// Loads, word stores and error responses complete in one cycle with the
// response registered; byte/half stores run a read-modify-write over
// IDLE -> RMW_RD -> RMW_WR because the memory only writes whole words.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : requester ports and memory port (slave modport)
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH = DMEM_DEPTH
) (
  input logic               clk,
  input logic               rst,
  dmem_access_ctrl_if.slave bus
);
  dmem_state_e r_state, w_state_nxt;
  logic        w_idle, w_gnt_p, w_gnt_d, w_gnt;
  logic        w_we, w_uns, w_err, w_sub;
  logic [1:0]  w_size;
  logic [31:0] w_addr, w_wdata;

  logic [31:0] r_addr, r_wdata, r_merge;
  logic [1:0]  r_size;
  logic        r_owner_d;

  logic        r_rsp_valid, r_rsp_d, r_rsp_err;
  logic [31:0] r_rsp_rdata;
  logic        w_rsp_valid_nxt, w_rsp_d_nxt, w_rsp_err_nxt;
  logic [31:0] w_rsp_rdata_nxt;

  assign w_idle = (r_state == IDLE);

  dmem_rr_arb2 u_arb (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_en    (w_idle),
    .i_req_p (bus.p_req_valid),
    .i_req_d (bus.d_req_valid),
    .o_gnt_p (w_gnt_p),
    .o_gnt_d (w_gnt_d)
  );

  assign w_gnt           = w_gnt_p | w_gnt_d;
  assign bus.p_req_ready = w_gnt_p;
  assign bus.d_req_ready = w_gnt_d;

  // Fields of whichever port holds the grant (p when nobody does; unused then).
  assign w_we    = w_gnt_d ? bus.d_req_we       : bus.p_req_we;
  assign w_uns   = w_gnt_d ? bus.d_req_unsigned : bus.p_req_unsigned;
  assign w_size  = w_gnt_d ? bus.d_req_size     : bus.p_req_size;
  assign w_addr  = w_gnt_d ? bus.d_req_addr     : bus.p_req_addr;
  assign w_wdata = w_gnt_d ? bus.d_req_wdata    : bus.p_req_wdata;

  always_comb begin
    w_err = 1'b0;
    case (w_size)
      BYTE:    w_err = 1'b0;
      HALF:    w_err = w_addr[0];
      WORD:    w_err = |w_addr[1:0];
      default: w_err = 1'b1;
    endcase
    if (w_addr[31:2] >= 30'(DEPTH)) w_err = 1'b1;
  end

  assign w_sub = w_gnt && w_we && !w_err && (w_size != WORD);

  // Memory port and next state. Kept apart from the response logic so the
  // combinational mem_addr -> mem_rdata path does not fold back into one block.
  always_comb begin
    w_state_nxt   = r_state;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    case (r_state)
      IDLE: begin
        if (w_gnt && !w_err) begin
          bus.mem_addr = w_addr;
          if (w_we && (w_size == WORD)) begin
            bus.mem_we    = 1'b1;
            bus.mem_wdata = w_wdata;
          end
          if (w_sub) w_state_nxt = RMW_RD;
        end
      end
      RMW_RD: begin
        bus.mem_addr = r_addr;
        w_state_nxt  = RMW_WR;
      end
      RMW_WR: begin
        bus.mem_we    = 1'b1;
        bus.mem_addr  = r_addr;
        bus.mem_wdata = store_merge(r_merge, r_wdata, r_addr[1:0], r_size);
        w_state_nxt   = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Response for the next cycle; RMW_WR and IDLE grants are mutually exclusive.
  always_comb begin
    w_rsp_valid_nxt = 1'b0;
    w_rsp_d_nxt     = r_rsp_d;
    w_rsp_err_nxt   = 1'b0;
    w_rsp_rdata_nxt = '0;
    if (r_state == RMW_WR) begin
      w_rsp_valid_nxt = 1'b1;
      w_rsp_d_nxt     = r_owner_d;
    end else if (w_gnt && !w_sub) begin
      w_rsp_valid_nxt = 1'b1;
      w_rsp_d_nxt     = w_gnt_d;
      w_rsp_err_nxt   = w_err;
      if (!w_err && !w_we)
        w_rsp_rdata_nxt = load_extend(bus.mem_rdata, w_addr[1:0], w_size, w_uns);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_rsp_valid <= 1'b0;
      r_rsp_d     <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_d     <= w_rsp_d_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
    end
  end

  // Sub-word store context; only meaningful while the FSM is out of IDLE.
  always_ff @(posedge clk) begin
    if (w_sub) begin
      r_addr    <= w_addr;
      r_size    <= w_size;
      r_wdata   <= w_wdata;
      r_owner_d <= w_gnt_d;
    end
    if (r_state == RMW_RD) r_merge <= bus.mem_rdata;
  end

  // Steer the single response register to its owning port only.
  assign bus.p_rsp_valid = r_rsp_valid & ~r_rsp_d;
  assign bus.p_rsp_err   = r_rsp_err & ~r_rsp_d;
  assign bus.p_rsp_rdata = r_rsp_d ? '0 : r_rsp_rdata;
  assign bus.d_rsp_valid = r_rsp_valid & r_rsp_d;
  assign bus.d_rsp_err   = r_rsp_err & r_rsp_d;
  assign bus.d_rsp_rdata = r_rsp_d ? r_rsp_rdata : '0;
endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Sits between the data memory and its two requesters: the pipeline MEM stage (`p_` port) and the debug/program-loader port (`d_` port). Arbitrates round-robin and issues byte/halfword/word loads with sign or zero extension. Performs sub-word stores as a two-cycle read-modify-write against the word-only memory. Rejects misaligned or out-of-range accesses with an error response.

## Interface

Parameters:
- `DEPTH`, 64: memory depth in 32-bit words; word index is `addr[31:2]`.

Ports (X ∈ {p, d}; each signal exists per port):
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `X_req_valid`  in  1  request present
- `X_req_ready`  out  1  request accepted this cycle (valid && ready)
- `X_req_we`  in  1  1 = store, 0 = load
- `X_req_size`  in  2  00 byte, 01 half, 10 word; 11 is illegal
- `X_req_unsigned`  in  1  zero-extend load (LBU/LHU)
- `X_req_addr`  in  32  byte address
- `X_req_wdata`  in  32  store data, right-aligned
- `X_rsp_valid`  out  1  one-cycle response pulse; no backpressure
- `X_rsp_rdata`  out  32  extended load data; 0 for stores and errors
- `X_rsp_err`  out  1  misaligned, out-of-range or illegal size
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  32  memory byte address
- `mem_wdata`  out  32  memory write data
- `mem_rdata`  in  32  memory read data, combinational from `mem_addr`

## Operation

- FSM states: IDLE, RMW_RD, RMW_WR.
- **IDLE arbitration**
  - One valid requester: it is granted.
  - Both valid: grant the port not granted last.
  - The last-granted pointer updates on every grant.
- **Error check (IDLE).** A request is an error if any of these holds:
  - half with `addr[0]=1`;
  - word with `addr[1:0]≠0`;
  - size 11;
  - `addr[31:2] ≥ DEPTH`.
  - Response: accept it, `mem_we=0`, `rsp_err=1`, `rsp_rdata=0`.
- **Load.** `mem_addr=addr`. Select the byte or half by `addr[1:0]`/`addr[1]`, extend per `unsigned`, and register into `rsp_rdata`.
- **Word store.** `mem_we=1`, `mem_wdata=wdata` in the accept cycle.
- **Sub-word store**
  - IDLE: latch addr, size and wdata, then go to RMW_RD.
  - RMW_RD: `mem_addr`=latched address; capture `mem_rdata` into the merge register; go to RMW_WR.
  - RMW_WR: `mem_we=1`; `mem_wdata`=captured word with the target byte or half lanes replaced by wdata[7:0] or wdata[15:0]; go to IDLE.
- `X_req_ready` is 0 for both ports in RMW_RD and RMW_WR. The losing port waits.
- Response goes only to the owning port. Only one port's `rsp_valid` is high in any cycle.
- `mem_we` is 0 in every case not listed above. `mem_addr` and `mem_wdata` are don't-care when idle but driven to 0.

## Timing

- **Reset values**
  - state IDLE, pointer = d, so p wins the first tie;
  - all `rsp_valid`, `rsp_err`, `rsp_rdata` = 0;
  - `mem_we` = 0.
- **Latency**
  - Load, word store, error: accept at cycle N, `rsp_valid` at N+1.
  - Sub-word store: accept at N, read at N+1, write at N+2, `rsp_valid` at N+3.
- **Throughput**
  - Load, word store, error: one per cycle, back-to-back.
  - Sub-word store: next accept at N+3. This is the same cycle as its response.
- `req_ready` is combinational from state and valids. Requesters must hold their fields stable while valid && !ready.
- Reset asserted during RMW_RD/RMW_WR abandons the store: no write occurs, no response is issued.
- Memory write takes effect at the clock edge ending a `mem_we=1` cycle. A load of the same word in the following cycle sees the new data.

## Structure

- Package `dmem_pkg`:
  - `size_e` enum (BYTE, HALF, WORD);
  - `dmem_state_e` enum (IDLE, RMW_RD, RMW_WR);
  - default `DMEM_DEPTH=64`;
  - pure functions `load_extend(word, offset, size, unsigned)` and `store_merge(word, wdata, offset, size)`.
- Sub-module `dmem_rr_arb2`: 2-requester round-robin with pointer, `en` input gating grants. It is instantiated once.

## Test plan

- **Reset.** Assert `rst=0` mid-operation. Expect all `rsp_*` = 0 and `mem_we=0`; after release the first tie grants p.
- **Word store then loads.** p stores word 0xDEADBEEF at 0x10. Then p issues LB at 0x13 → `rsp_rdata=0xFFFFFFDE`; LBU 0x13 → 0x000000DE; LH 0x10 → 0xFFFFBEEF. Each response comes 1 cycle after accept.
- **Sub-word RMW.** After the above, SB 0x55 to 0x11. Expect `mem_we` only at N+2 with `mem_wdata=0xDEAD55EF`, `rsp_valid` at N+3, and `req_ready` low for both ports at N+1 and N+2.
- **Tie and alternation.** p and d continuously valid with loads. Grants alternate p,d,p,d; each response appears only on the granted port.
- **Errors.**
  - LW 0x0000_0102 → `err=1`, `rdata=0`, `mem_we` never asserted.
  - SW to word index 64 (DEPTH=64) → `err=1`.
  - size=11 → `err=1`.
- **Reset during RMW.** SH accepted, reset asserted in RMW_RD. No write, no `rsp_valid`; the memory word is unchanged afterwards.
